// File: rtl/set_job_arbiter.sv
// -----------------------------------------------------------------------------
// set_job_arbiter
//   Two-port round-robin job scheduler in front of a single SET
//   candidate-counting core. It accepts one job at a time, starts the core,
//   captures the core result and returns it tagged with the requester id.
//
// Parameters
//   GAP      idle cycles after each response before the next accept (0 allowed)
//   TIMEOUT  WAIT-state cycle limit, >= 1 (used only with SET_ARB_TIMEOUT_EN)
//
// Build option
//   SET_ARB_TIMEOUT_EN  when defined, a job whose core never answers is
//                       closed after TIMEOUT WAIT cycles with rsp_err=1 and
//                       rsp_candidate=0. Undefined: rsp_err is tied low and
//                       WAIT exits only on core_valid.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid / reqN_ready      job offer / one-cycle accept pulse (N = 0,1)
//   reqN_central/radius/mode     job operands (24 / 12 / 2 bits)
//   rsp_valid, rsp_id            one-cycle response strobe, owning requester
//   rsp_candidate, rsp_err       captured result, timeout flag
//   core_en                      one-cycle start pulse to the core
//   core_central/radius/mode     operands held for the core
//   core_valid, core_candidate   core result strobe and value
//   job_cnt                      responses issued since reset (wraps)
//
// FSM states
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for a request; grants and latches operands
//   S_ISSUE | core_en high for this single cycle
//   S_WAIT  | waiting for core_valid (or timeout)
//   S_RESP  | rsp_valid high, response fields valid
//   S_GAP   | GAP idle cycles, no accepts
// -----------------------------------------------------------------------------
module set_job_arbiter #(
    parameter int         GAP     = 2,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] req0_central,
    input  logic [11:0] req0_radius,
    input  logic [1:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_central,
    input  logic [11:0] req1_radius,
    input  logic [1:0]  req1_mode,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_candidate,
    output logic        rsp_err,
    output logic        core_en,
    output logic [23:0] core_central,
    output logic [11:0] core_radius,
    output logic [1:0]  core_mode,
    input  logic        core_valid,
    input  logic [7:0]  core_candidate,
    output logic [15:0] job_cnt
);

    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             cur_id;
    logic [GAP_W-1:0] gap_cnt;
    logic             any_req;
    logic             grant_id;
    logic             accept;

`ifdef SET_ARB_TIMEOUT_EN
    logic [7:0]       wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // Ready must be asserted in the same cycle the request is seen, so the
    // grant is combinational; everything it triggers is registered. It is
    // gated by rst so nothing is accepted while reset is held.
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
        accept = !rst && (state == S_IDLE) && any_req;
    end

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept &  grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            cur_id        <= 1'b0;
            gap_cnt       <= '0;
            core_en       <= 1'b0;
            core_central  <= '0;
            core_radius   <= '0;
            core_mode     <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_candidate <= '0;
            job_cnt       <= '0;
`ifdef SET_ARB_TIMEOUT_EN
            rsp_err       <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            core_en   <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        core_central <= grant_id ? req1_central : req0_central;
                        core_radius  <= grant_id ? req1_radius  : req0_radius;
                        core_mode    <= grant_id ? req1_mode    : req0_mode;
                        cur_id       <= grant_id;
                        last_grant   <= grant_id;
                        core_en      <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef SET_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A result in the same cycle as the timeout terminal
                    // count takes priority and is reported without error.
                    if (core_valid) begin
                        rsp_candidate <= core_candidate;
                        rsp_id        <= cur_id;
                        rsp_valid     <= 1'b1;
                        job_cnt       <= job_cnt + 16'd1;
                        state         <= S_RESP;
`ifdef SET_ARB_TIMEOUT_EN
                        rsp_err       <= 1'b0;
                    end else if (wait_cnt == TIMEOUT - 8'd1) begin
                        // wait_cnt+1 would reach TIMEOUT on this cycle
                        rsp_candidate <= '0;
                        rsp_err       <= 1'b1;
                        rsp_id        <= cur_id;
                        rsp_valid     <= 1'b1;
                        job_cnt       <= job_cnt + 16'd1;
                        state         <= S_RESP;
                    end else begin
                        wait_cnt      <= wait_cnt + 8'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (GAP == 0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= GAP_W'(GAP);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state <= S_IDLE;
                    end
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/set_job_arbiter.md
# set_job_arbiter

Two-port job scheduler for the SET candidate-counting core. It accepts circle-set jobs (centres, radii, mode) from two requesters and arbitrates between them round-robin. It drives the core's `en`/operand inputs with one job at a time, captures `candidate` on the core's `valid` pulse, and returns it tagged with the requester id. It sits between the system-level job sources and a single SET core instance.

## Interface
Parameters:
- `GAP`, 2: idle cycles after each response before the next job may be accepted (0 allowed).
- `TIMEOUT`, 255: WAIT-state cycle limit; used only with `SET_ARB_TIMEOUT_EN`; 8-bit, must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a job pending.
- `req0_ready` out 1: one-cycle accept pulse for requester 0.
- `req0_central` in 24: {x1,y1,x2,y2,…}, 4 bits per field, same packing as the core.
- `req0_radius` in 12: {r1,r2,…}.
- `req0_mode` in 2: core mode.
- `req1_valid`, `req1_ready`, `req1_central`, `req1_radius`, `req1_mode`: same for requester 1.
- `rsp_valid` out 1: one-cycle response strobe; no backpressure.
- `rsp_id` out 1: requester that owned the job.
- `rsp_candidate` out 8: captured core result.
- `rsp_err` out 1: job timed out (constant 0 without macro).
- `core_en` out 1: start pulse to core.
- `core_central` out 24, `core_radius` out 12, `core_mode` out 2: registered operands to core.
- `core_valid` in 1: core result strobe.
- `core_candidate` in 8: core result.
- `job_cnt` out 16: responses issued since reset; wraps 0xFFFF→0.

## Operation
- FSM states:
  - IDLE→ISSUE: on acceptance.
  - ISSUE→WAIT: always.
  - WAIT→RESP: on `core_valid`, or on timeout.
  - RESP→GAP: always; RESP→IDLE directly if GAP=0.
  - GAP→IDLE: after GAP cycles.
- IDLE acceptance:
  - If any `reqN_valid`=1, grant one requester.
  - Latch its central/radius/mode into the core operand registers and its id into `cur_id`.
  - Pulse that `reqN_ready` for the same cycle.
- Arbitration:
  - Single requester valid → grant it.
  - Both valid → grant the one not granted last.
  - Last-grant pointer resets to 1, so requester 0 wins the first tie.
  - Pointer updates only on a grant.
- ISSUE: `core_en`=1 for exactly one cycle.
- Operand hold: core operand registers hold unchanged from the accept edge until the next accept; they are never modified mid-job.
- WAIT:
  - `core_valid`=1 → capture `core_candidate` into the response register and set err=0.
  - `core_valid` in any other state is ignored.
- RESP:
  - `rsp_valid`=1 with `rsp_id`=`cur_id`, `rsp_candidate`, and `rsp_err`.
  - `job_cnt` increments.
- GAP: a down-counter loaded with GAP; `reqN_ready` stays low.
- Outputs outside RESP: `rsp_candidate`/`rsp_id`/`rsp_err` retain their last values; only `rsp_valid` qualifies them.
- Requester dropping `reqN_valid` before being granted: no effect, no state.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_candidate`=0, `rsp_err`=0, `core_en`=0, `core_central`=0, `core_radius`=0, `core_mode`=0, `job_cnt`=0; state IDLE; pointer=1.
- Latency chain:
  - Accept at cycle T.
  - `core_en` at T+1.
  - Core asserts `core_valid` at T+1+L.
  - `rsp_valid` at T+2+L.
  - Earliest next `reqN_ready` at T+3+L+GAP.
- `rst` mid-job:
  - All outputs return to reset values on the next edge.
  - The in-flight job is dropped with no response.
  - A `core_valid` arriving afterward is ignored, since the FSM is in IDLE.
- `core_valid` coincident with the timeout terminal count: valid wins, err=0.

## Configuration
- `SET_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without `core_valid`: go to RESP with `rsp_err`=1 and `rsp_candidate`=0.
  - Then proceed normally.
- Undefined:
  - No counter; `rsp_err` tied 0.
  - WAIT exits only on `core_valid`.

## Test plan
- Single job: req0, central=0x4400_00, radius=0x200, mode=0; model core L=64 returns 13 → `req0_ready` one pulse; `core_en` one cycle after; `rsp_valid` at cycle after `core_valid`, `rsp_id`=0, `rsp_candidate`=13, `job_cnt`=1.
- Contention: req0 and req1 both valid continuously for 4 jobs → grants 0,1,0,1; `rsp_id` sequence 0,1,0,1; each accept exactly GAP+1 cycles after the prior `rsp_valid`.
- Operand hold: change `req0_central` after acceptance while the job runs → `core_central` stays at the accepted value until RESP.
- Reset mid-WAIT: assert `rst` 10 cycles after `core_en`, then `core_valid` arrives → no `rsp_valid`, `job_cnt`=0, all outputs at reset values.
- Timeout (macro on, TIMEOUT=20): core never responds → `rsp_valid` 21 cycles after `core_en` with `rsp_err`=1, `rsp_candidate`=0; next job still served normally. Macro off: no response, FSM stays in WAIT.
- GAP=0 and `job_cnt` wrap: preload 0xFFFF jobs via a force, run one more job → `job_cnt`=0, and a new accept occurs the cycle after RESP.
